// File: rtl/simple_bfm_target.sv
// Request responder for the simple BFM: acknowledges each req/data handshake after
// ACK_DELAY wait cycles and buffers accepted bytes in a show-ahead FIFO drained by valid/ready.
module simple_bfm_target #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ACK_DELAY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic [7:0]                 data,
  output logic                       ack,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                xfer_count,
  output logic                       err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [3:0]    DLY_INIT = 4'(ACK_DELAY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      dly_q;
  logic            ack_q;
  logic            err_q;
  logic [15:0]     xfer_count_q;

  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q,  level_d;

  logic            full;
  logic            push;
  logic            pop;

  // Full is judged on the current level only, so a same-edge pop never makes room for a push.
  assign full = (level_q == FULL_LVL);
  assign push = (state_q == WAIT) && req && (dly_q == 4'd0) && !full;
  assign pop  = (level_q != '0) && out_ready;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dly_q        <= 4'd0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      xfer_count_q <= 16'd0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            dly_q   <= DLY_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (dly_q != 4'd0) begin
            dly_q <= dly_q - 4'd1;
          end else if (push) begin
            ack_q        <= 1'b1;
            xfer_count_q <= xfer_count_q + 16'd1;
            state_q      <= ACK;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; level and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign xfer_count = xfer_count_q;
  assign level      = level_q;
  assign out_valid  = (level_q != '0);
  assign out_data   = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_simple_bfm_target.sv
// Directed bench for simple_bfm_target: one instance with ACK_DELAY=1 and one with
// ACK_DELAY=0, both DEPTH=4, sharing clock and reset.
module tb_simple_bfm_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       req1 = 1'b0, ack1, out_valid1, out_ready1 = 1'b0, err1;
  logic [7:0] data1 = 8'h00, out_data1;
  logic [2:0] level1;
  logic [15:0] xfer1;

  logic       req0 = 1'b0, ack0, out_valid0, out_ready0 = 1'b0, err0;
  logic [7:0] data0 = 8'h00, out_data0;
  logic [2:0] level0;
  logic [15:0] xfer0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simple_bfm_target #(.DEPTH(4), .ACK_DELAY(1)) u_d1 (
    .clk(clk), .rst(rst), .req(req1), .data(data1), .ack(ack1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
    .level(level1), .xfer_count(xfer1), .err(err1)
  );

  simple_bfm_target #(.DEPTH(4), .ACK_DELAY(0)) u_d0 (
    .clk(clk), .rst(rst), .req(req0), .data(data0), .ack(ack0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready0),
    .level(level0), .xfer_count(xfer0), .err(err0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise req with a byte, count cycles until ack, check that latency, then drop req.
  // Latency is 2+ACK_DELAY from IDLE and one more when issued during the ACK cycle.
  task automatic do_req(input bit sel, input logic [7:0] d, input int exp_lat, input string tag);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    if (sel) begin req0 = 1'b1; data0 = d; end
    else     begin req1 = 1'b1; data1 = d; end
    while (!got && n < 20) begin
      tick();
      n++;
      got = sel ? ack0 : ack1;
      if (sel) check({tag, "_lvl_le1"}, 32'(level0 <= 3'd1), 32'd1);
    end
    check({tag, "_ack_lat"}, got ? n : -1, exp_lat);
    if (sel) req0 = 1'b0;
    else     req1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick();
    tick();
    rst = 1'b0;
    check("rst_ack",   32'(ack1),       32'd0);
    check("rst_valid", 32'(out_valid1), 32'd0);
    check("rst_level", 32'(level1),     32'd0);
    check("rst_xfer",  32'(xfer1),      32'd0);
    check("rst_err",   32'(err1),       32'd0);

    // Single request, ACK_DELAY=1: ack in the cycle after edge T0+2
    out_ready1 = 1'b1;
    do_req(1'b0, 8'hA5, 3, "t1");
    check("t1_data",  32'(out_data1),  32'hA5);
    check("t1_valid", 32'(out_valid1), 32'd1);
    check("t1_level", 32'(level1),     32'd1);
    check("t1_xfer",  32'(xfer1),      32'd1);
    tick();
    check("t1_ack_pulse", 32'(ack1),       32'd0);
    check("t1_valid_off", 32'(out_valid1), 32'd0);
    check("t1_level0",    32'(level1),     32'd0);

    // Fill to DEPTH with out_ready low, fifth request stalls
    out_ready1 = 1'b0;
    do_req(1'b0, 8'h01, 3, "f1");
    do_req(1'b0, 8'h02, 4, "f2");
    do_req(1'b0, 8'h03, 4, "f3");
    do_req(1'b0, 8'h04, 4, "f4");
    check("full_level", 32'(level1),    32'd4);
    check("full_head",  32'(out_data1), 32'h01);
    req1  = 1'b1;
    data1 = 8'h05;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_ack", 32'(ack1), 32'd0);
    end
    check("stall_level", 32'(level1), 32'd4);
    out_ready1 = 1'b1;
    tick();
    check("pop_no_push_ack", 32'(ack1),      32'd0);
    check("pop_level",       32'(level1),    32'd3);
    check("drain_02",        32'(out_data1), 32'h02);
    tick();
    check("fifth_ack",   32'(ack1),      32'd1);
    check("fifth_level", 32'(level1),    32'd3);
    check("drain_03",    32'(out_data1), 32'h03);
    req1 = 1'b0;
    tick();
    check("drain_04", 32'(out_data1), 32'h04);
    tick();
    check("drain_05",   32'(out_data1), 32'h05);
    check("drain_lvl1", 32'(level1),    32'd1);
    tick();
    check("drain_empty", 32'(out_valid1), 32'd0);
    check("xfer_6",      32'(xfer1),      32'd6);

    // Protocol violation: drop req while in WAIT
    out_ready1 = 1'b0;
    do_req(1'b0, 8'h11, 3, "e0");
    tick();
    req1  = 1'b1;
    data1 = 8'h77;
    tick();
    req1 = 1'b0;
    tick();
    check("err_set",   32'(err1),   32'd1);
    check("err_noack", 32'(ack1),   32'd0);
    check("err_level", 32'(level1), 32'd1);
    check("err_xfer",  32'(xfer1),  32'd7);
    tick();
    tick();
    check("err_sticky", 32'(err1), 32'd1);
    do_req(1'b0, 8'h22, 3, "e1");
    check("err_still", 32'(err1),   32'd1);
    check("lvl2",      32'(level1), 32'd2);

    // Reset mid-handshake, in WAIT with level=2
    tick();
    req1  = 1'b1;
    data1 = 8'h33;
    tick();
    rst = 1'b1;
    #1;
    check("mrst_ack",   32'(ack1),       32'd0);
    check("mrst_level", 32'(level1),     32'd0);
    check("mrst_valid", 32'(out_valid1), 32'd0);
    check("mrst_xfer",  32'(xfer1),      32'd0);
    check("mrst_err",   32'(err1),       32'd0);
    tick();
    rst  = 1'b0;
    req1 = 1'b0;
    out_ready1 = 1'b1;
    tick();
    do_req(1'b0, 8'h44, 3, "post_rst");
    check("post_rst_data",  32'(out_data1), 32'h44);
    check("post_rst_level", 32'(level1),    32'd1);
    check("post_rst_xfer",  32'(xfer1),     32'd1);

    // ACK_DELAY=0, continuous req: first from IDLE, rest issued in the ACK cycle
    out_ready0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, 8'h10 + 8'(i), (i == 0) ? 2 : 3, "d0");
      check("d0_data",  32'(out_data0), 32'(8'h10 + 8'(i)));
      check("d0_level", 32'(level0),    32'd1);
    end
    check("d0_xfer", 32'(xfer0), 32'd5);

    // Counter wrap: preload near 16'hFFFF, then three requests end at 1
    tick();
    force u_d0.xfer_count_q = 16'hFFFE;
    #1;
    release u_d0.xfer_count_q;
    do_req(1'b1, 8'hE0, 2, "w0");
    check("wrap_ffff", 32'(xfer0), 32'hFFFF);
    do_req(1'b1, 8'hE1, 3, "w1");
    check("wrap_0000", 32'(xfer0), 32'h0000);
    do_req(1'b1, 8'hE2, 3, "w2");
    check("wrap_0001", 32'(xfer0), 32'h0001);
    check("d0_err",    32'(err0),  32'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
